// File: rtl/cu_pkg.sv
// Shared control-unit constants: T-state and M-cycle encodings, plus
// the bit positions of the condition vector and the flag nibble.
package cu_pkg;

  localparam logic [3:0] T1 = 4'b0001;
  localparam logic [3:0] T2 = 4'b0010;
  localparam logic [3:0] T3 = 4'b0100;
  localparam logic [3:0] T4 = 4'b1000;

  // M1 is bit 0 of the one-hot M-cycle counter, whatever its width.
  localparam int M1_BIT = 0;

  localparam int COND_NZ = 0;
  localparam int COND_Z  = 1;
  localparam int COND_NC = 2;
  localparam int COND_C  = 3;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  // Advance the one-hot T-state: T1 -> T2 -> T3 -> T4 -> T1.
  function automatic logic [3:0] next_step(input logic [3:0] step);
    return {step[2:0], step[3]};
  endfunction

endpackage

// File: rtl/opcode_field_decode.sv
// Splits an opcode byte into one-hot x/y/z/p/q fields. Purely
// combinational so the CB-prefix page can reuse it unchanged.
module opcode_field_decode (
  input  logic [7:0] i_Byte,
  output logic [3:0] o_X,
  output logic [7:0] o_Y,
  output logic [7:0] o_Z,
  output logic [3:0] o_P,
  output logic [1:0] o_Q
);

  // Each field is a shifted single bit, so exactly one bit is always set.
  always_comb begin
    // NOTE: every output gets a full assignment on every path, so no latch
    // can be inferred even if a case/if is added here later.
    o_X = 4'b0001 << i_Byte[7:6];
    o_Y = 8'b0000_0001 << i_Byte[5:3];
    o_Z = 8'b0000_0001 << i_Byte[2:0];
    o_P = 4'b0001 << i_Byte[5:4];
    o_Q = 2'b01 << i_Byte[3];
  end

endmodule

// File: rtl/opcode_sequencer.sv
// Control-unit front end: instruction register, T-state / M-cycle
// sequencing, one-hot opcode fields and the branch condition vector.
module opcode_sequencer
  import cu_pkg::*;
#(
  parameter int MAX_M_CYCLES = 8
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [7:0]              i_Data_Bus,
  input  logic                    i_Fetch,
  input  logic                    i_Wait,
  input  logic [3:0]              i_Flags,
  output logic [7:0]              o_Opcode,
  output logic [3:0]              o_X,
  output logic [7:0]              o_Y,
  output logic [7:0]              o_Z,
  output logic [3:0]              o_P,
  output logic [1:0]              o_Q,
  output logic [3:0]              o_Cycle_Step,
  output logic [MAX_M_CYCLES-1:0] o_Cycle_Count,
  output logic [3:0]              o_Conditions,
  output logic                    o_IR_Load,
  output logic                    o_Fault
);

  localparam logic [MAX_M_CYCLES-1:0] COUNT_M1 =
    {{(MAX_M_CYCLES-1){1'b0}}, 1'b1} << M1_BIT;

  logic [3:0] dec_x;
  logic [7:0] dec_y;
  logic [7:0] dec_z;
  logic [3:0] dec_p;
  logic [1:0] dec_q;

  // Decode the incoming byte so the fields load on the same edge as IR.
  opcode_field_decode u_field_decode (
    .i_Byte (i_Data_Bus),
    .o_X    (dec_x),
    .o_Y    (dec_y),
    .o_Z    (dec_z),
    .o_P    (dec_p),
    .o_Q    (dec_q)
  );

  // Sequencing: rotate T-state, and at T4 either load a new opcode or
  // advance (saturating) the M-cycle counter. Wait freezes everything.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Opcode      <= 8'h00;
      o_X           <= 4'b0001;
      o_Y           <= 8'b0000_0001;
      o_Z           <= 8'b0000_0001;
      o_P           <= 4'b0001;
      o_Q           <= 2'b01;
      o_Cycle_Step  <= T1;
      o_Cycle_Count <= COUNT_M1;
      o_IR_Load     <= 1'b0;
      o_Fault       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge values regardless of statement order.
      o_IR_Load <= 1'b0;
      if (!i_Wait) begin
        o_Cycle_Step <= next_step(o_Cycle_Step);
        if (o_Cycle_Step == T4) begin
          if (i_Fetch) begin
            o_Opcode      <= i_Data_Bus;
            o_X           <= dec_x;
            o_Y           <= dec_y;
            o_Z           <= dec_z;
            o_P           <= dec_p;
            o_Q           <= dec_q;
            o_Cycle_Count <= COUNT_M1;
            o_IR_Load     <= 1'b1;
          end else if (o_Cycle_Count[MAX_M_CYCLES-1]) begin
            o_Fault <= 1'b1;
          end else begin
            o_Cycle_Count <= o_Cycle_Count << 1;
          end
        end
      end
    end
  end

  // N and H do not feed any branch condition.
  logic flags_unused;
  assign flags_unused = i_Flags[FLAG_N] ^ i_Flags[FLAG_H];

  // Branch conditions follow the flags combinationally.
  always_comb begin
    o_Conditions          = 4'b0000;
    o_Conditions[COND_NZ] = ~i_Flags[FLAG_Z];
    o_Conditions[COND_Z]  =  i_Flags[FLAG_Z];
    o_Conditions[COND_NC] = ~i_Flags[FLAG_C];
    o_Conditions[COND_C]  =  i_Flags[FLAG_C];
  end

endmodule
